// File: rtl/barrier_sequencer.sv
// Toll-lane barrier motor sequencer: drives motor_up/motor_down from open/close requests,
// limit switches, exit-sensor obstruction and travel/hold timeouts; counts passing vehicles.
module barrier_sequencer #(
  parameter int unsigned TRAVEL_MAX = 50_000_000,
  parameter int unsigned HOLD_MAX   = 250_000_000,
  parameter int unsigned TMR_W      = 32,
  parameter int unsigned PASS_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              up,
  input  logic              dis,
  input  logic              sensor3,
  input  logic              lim_open,
  input  logic              lim_closed,
  input  logic              clr_fault,
  output logic              motor_up,
  output logic              motor_down,
  output logic              gate_open,
  output logic              gate_closed,
  output logic              fault,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    StClosed  = 3'd0,
    StOpening = 3'd1,
    StOpen    = 3'd2,
    StClosing = 3'd3,
    StFault   = 3'd4
  } state_e;

  localparam logic [TMR_W-1:0] TravelLast = TMR_W'(TRAVEL_MAX - 1);
  localparam logic [TMR_W-1:0] HoldLast   = TMR_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              close_pend_q, close_pend_d;
  logic              sensor3_q;
  logic [PASS_W-1:0] pass_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StClosed;
      timer_q      <= '0;
      close_pend_q <= 1'b0;
      sensor3_q    <= 1'b0;
      pass_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      close_pend_q <= close_pend_d;
      sensor3_q    <= sensor3;
      if (sensor3_q && !sensor3 && (state_q != StFault)) begin
        pass_q <= pass_q + PASS_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    close_pend_d = close_pend_q;
    unique case (state_q)
      StClosed: begin
        if (up) begin
          state_d = StOpening;
        end else if (!lim_closed && !sensor3) begin
          // Barrier not down after reset or drift: re-close once the lane is clear.
          state_d = StClosing;
        end
      end
      StOpening: begin
        if (lim_open && lim_closed)   state_d = StFault;
        else if (lim_open)            state_d = StOpen;
        else if (timer_q == TravelLast) state_d = StFault;
        else                          timer_d = timer_q + TMR_W'(1);
      end
      StOpen: begin
        if (up) begin
          timer_d      = '0;
          close_pend_d = 1'b0;
        end else if (dis && !sensor3) begin
          state_d = StClosing;
        end else if (dis) begin
          close_pend_d = 1'b1;
          timer_d      = '0;
        end else if (close_pend_q && !sensor3) begin
          state_d = StClosing;
        end else if (sensor3) begin
          timer_d = '0;
        end else if (timer_q == HoldLast) begin
          state_d = StClosing;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      StClosing: begin
        if (lim_open && lim_closed)     state_d = StFault;
        else if (sensor3 || up)         state_d = StOpening;
        else if (lim_closed)            state_d = StClosed;
        else if (timer_q == TravelLast) state_d = StFault;
        else                            timer_d = timer_q + TMR_W'(1);
      end
      StFault: begin
        if (clr_fault) state_d = StClosed;
      end
      default: state_d = StClosed;
    endcase
    if (state_d != state_q) begin
      timer_d      = '0;
      close_pend_d = 1'b0;
    end
  end

  always_comb begin
    motor_up    = 1'b0;
    motor_down  = 1'b0;
    gate_open   = 1'b0;
    gate_closed = 1'b0;
    fault       = 1'b0;
    unique case (state_q)
      StClosed:  gate_closed = 1'b1;
      StOpening: motor_up    = 1'b1;
      StOpen:    gate_open   = 1'b1;
      StClosing: motor_down  = 1'b1;
      StFault:   fault       = 1'b1;
      default:   gate_closed = 1'b0;
    endcase
  end

  assign pass_cnt = pass_q;

endmodule
